// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and defaults for the Gray counter slice.
// Functions work on MAX_WIDTH-bit vectors; narrower values are zero-extended by the caller.
package gray_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 16;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits of a zero-extended Gray value decode to zero binary bits.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_step_checker.sv
// Sticky detector for Gray steps that do not change exactly one bit.
// Only instantiated when GRAY_STEP_CHECK_EN is defined.
module gray_step_checker
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             check,
  input  logic [WIDTH-1:0] gray_next,
  input  logic [WIDTH-1:0] gray_cur,
  output logic             step_err
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] diff;
  logic [CW-1:0]    psum [WIDTH+1];
  logic             step_err_reg;

  assign diff    = gray_next ^ gray_cur;
  assign psum[0] = '0;

  // Ripple popcount of the changed bits.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pop
    assign psum[gi+1] = psum[gi] + CW'(diff[gi]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_err_reg <= 1'b0;
    end else if (check && (psum[WIDTH] != CW'(1))) begin
      step_err_reg <= 1'b1;
    end
  end

  assign step_err = step_err_reg;

endmodule

// File: rtl/gray_code_counter.sv
// Up/down counter with registered Gray and binary outputs plus a wrap pulse.
// Define GRAY_STEP_CHECK_EN to build the sticky single-bit-step checker; otherwise step_err is 0.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int          WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary,
  output logic             wrap,
  output logic             step_err
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(MAX_WIDTH'(RST_BIN)));

  logic [WIDTH-1:0] binary_reg, binary_next;
  logic [WIDTH-1:0] gray_reg, gray_next;
  logic             wrap_reg, wrap_next;

  always_comb begin
    binary_next = binary_reg;
    wrap_next   = 1'b0;
    if (load) begin
      binary_next = load_val;
    end else if (en) begin
      if (up) begin
        binary_next = binary_reg + 1'b1;
        wrap_next   = (binary_reg == '1);
      end else begin
        binary_next = binary_reg - 1'b1;
        wrap_next   = (binary_reg == '0);
      end
    end
    // Gray is derived from the next count so both registers update together.
    gray_next = WIDTH'(bin2gray(MAX_WIDTH'(binary_next)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      binary_reg <= RST_BIN;
      gray_reg   <= RST_GRAY;
      wrap_reg   <= 1'b0;
    end else begin
      binary_reg <= binary_next;
      gray_reg   <= gray_next;
      wrap_reg   <= wrap_next;
    end
  end

  assign binary = binary_reg;
  assign gray   = gray_reg;
  assign wrap   = wrap_reg;

`ifdef GRAY_STEP_CHECK_EN
  gray_step_checker #(
    .WIDTH(WIDTH)
  ) u_step_checker (
    .clk      (clk),
    .rst_n    (rst_n),
    .check    (en & ~load),
    .gray_next(gray_next),
    .gray_cur (gray_reg),
    .step_err (step_err)
  );
`else
  assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_code_counter.sv
// Self-checking bench for gray_code_counter (WIDTH=4, RST_VAL=0): vector table,
// hand sequences and randomized traffic against an integer reference model.
module tb_gray_code_counter;
  import gray_pkg::*;

  localparam int W = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0, up = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] gray, binary;
  logic         wrap, step_err;

  int checks = 0;
  int errors = 0;

  gray_code_counter #(.WIDTH(W), .RST_VAL(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .gray(gray), .binary(binary), .wrap(wrap), .step_err(step_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         ld;
    logic [W-1:0] lv;
    logic         en;
    logic         up;
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         w;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int decode(input logic [W-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b = gray2bin(MAX_WIDTH'(g));
    return int'(b);
  endfunction

  function automatic int hamming(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(a[i] ^ b[i]);
    return n;
  endfunction

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_binary", int'(binary), 0);
    chk("reset_gray", int'(gray), 0);
    chk("reset_wrap", int'(wrap), 0);
    chk("reset_step_err", int'(step_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int m, exp_w, exp_err, prev_g;
  logic [3:0] up_seq [16];

  initial begin
    vecs[0]  = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  4'b0001, 1'b0};
    vecs[1]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  4'b0000, 1'b0};
    vecs[2]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd15, 4'b1000, 1'b1};
    vecs[3]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd14, 4'b1001, 1'b0};
    vecs[4]  = '{1'b1, 4'd10, 1'b1, 1'b1, 4'd10, 4'b1111, 1'b0};
    vecs[5]  = '{1'b0, 4'd3,  1'b0, 1'b1, 4'd10, 4'b1111, 1'b0};
    vecs[6]  = '{1'b1, 4'd10, 1'b0, 1'b0, 4'd10, 4'b1111, 1'b0};
    vecs[7]  = '{1'b1, 4'd5,  1'b1, 1'b0, 4'd5,  4'b0111, 1'b0};
    vecs[8]  = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd6,  4'b0101, 1'b0};
    vecs[9]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd5,  4'b0111, 1'b0};
    vecs[10] = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd6,  4'b0101, 1'b0};
    vecs[11] = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd5,  4'b0111, 1'b0};
    vecs[12] = '{1'b1, 4'd15, 1'b0, 1'b1, 4'd15, 4'b1000, 1'b0};
    vecs[13] = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd0,  4'b0000, 1'b1};
    vecs[14] = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  4'b0000, 1'b0};
    vecs[15] = '{1'b0, 4'd9,  1'b0, 1'b1, 4'd0,  4'b0000, 1'b0};

    up_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
               4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    @(negedge clk);
    do_reset();

    // Vector table
    for (int i = 0; i < 16; i++) begin
      load = vecs[i].ld; load_val = vecs[i].lv; en = vecs[i].en; up = vecs[i].up;
      step();
      $display("vec %0d: ld=%0b lv=%0d en=%0b up=%0b -> bin=%0d gray=%b wrap=%0b",
               i, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].up, binary, gray, wrap);
      chk($sformatf("vec%0d_binary", i), int'(binary), int'(vecs[i].b));
      chk($sformatf("vec%0d_gray", i), int'(gray), int'(vecs[i].g));
      chk($sformatf("vec%0d_wrap", i), int'(wrap), int'(vecs[i].w));
      chk($sformatf("vec%0d_step_err", i), int'(step_err), 0);
    end
    load = 1'b0; en = 1'b0;

    // Full up-count from 0 with a wrap on the 16th step
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      $display("upcount %0d: bin=%0d gray=%b wrap=%0b", i, binary, gray, wrap);
      chk($sformatf("up%0d_gray", i), int'(gray), int'(up_seq[i]));
      chk($sformatf("up%0d_decode", i), decode(gray), int'(binary));
      chk($sformatf("up%0d_wrap", i), int'(wrap), (i == 15) ? 1 : 0);
    end

    // Count to 9, then assert reset between edges
    for (int i = 0; i < 9; i++) step();
    chk("pre_reset_binary", int'(binary), 9);
    en = 1'b0;
    do_reset();
    step();
    chk("post_release_hold", int'(binary), 0);

    // Randomized traffic against the integer model
    m = 0;
    exp_err = 0;
    for (int t = 0; t < 400; t++) begin
      load = ($urandom_range(0, 9) == 0);
      load_val = W'($urandom_range(0, MOD - 1));
      en = ($urandom_range(0, 3) != 0);
      up = $urandom_range(0, 1) == 1;
      prev_g = int'(gray);
      if (load) begin
        m = int'(load_val); exp_w = 0;
      end else if (en) begin
        if (up) begin exp_w = (m == MOD - 1); m = (m + 1) % MOD; end
        else begin exp_w = (m == 0); m = (m + MOD - 1) % MOD; end
      end else begin
        exp_w = 0;
      end
      step();
      $display("rand %0d: ld=%0b lv=%0d en=%0b up=%0b -> bin=%0d gray=%b wrap=%0b",
               t, load, load_val, en, up, binary, gray, wrap);
      chk("rand_binary", int'(binary), m);
      chk("rand_decode", decode(gray), m);
      chk("rand_wrap", int'(wrap), exp_w);
      chk("rand_step_err", int'(step_err), exp_err);
      if (en && !load) chk("rand_hamming", hamming(gray, W'(prev_g)), 1);
    end
    load = 1'b0; en = 1'b0;

`ifdef GRAY_STEP_CHECK_EN
    load = 1'b1; load_val = 4'd3;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    force dut.binary_next = 4'd7;
    step();
    release dut.binary_next;
    $display("fault inject: bin=%0d gray=%b step_err=%0b", binary, gray, step_err);
    chk("inject_step_err", int'(step_err), 1);
    for (int i = 0; i < 4; i++) step();
    chk("sticky_step_err", int'(step_err), 1);
    en = 1'b0;
    do_reset();
    step();
    chk("cleared_step_err", int'(step_err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
